// File: rtl/prescaler_pkg.sv
// Shared constants, divisor type and channel-select width helper for the prescaler bank.
package prescaler_pkg;

  localparam int unsigned DIV_W_DEF     = 16;
  localparam int unsigned DIV_RESET_DEF = 60;
  localparam int unsigned MAX_CH        = 16;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Channel-select width, never narrower than one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: half-period counter, active/shadow divisor and registered outputs.
// Optional synchronous phase alignment input when PRESCALER_SYNC_EN is defined.
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int unsigned DivW     = DIV_W_DEF,
  parameter int unsigned DivReset = DIV_RESET_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [DivW-1:0] div_i,
`ifdef PRESCALER_SYNC_EN
  input  logic            sync_i,
`endif
  output logic            clk_o,
  output logic            tick_o,
  output logic            pending_o
);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] act_q, act_d;
  logic [DivW-1:0] shd_q, shd_d;
  logic            pend_q, pend_d;
  logic            clk_q, clk_d;
  logic            tick_q, tick_d;

  logic            running;
  logic            tc;
  logic            sync_hold;
  logic [DivW-1:0] next_div;

`ifdef PRESCALER_SYNC_EN
  assign sync_hold = sync_i;
`else
  assign sync_hold = 1'b0;
`endif

  assign running = (act_q != '0);
  assign tc      = running && (cnt_q == act_q - 1'b1);

  // A write landing on the terminal-count cycle bypasses the shadow.
  assign next_div = we_i ? div_i : (pend_q ? shd_q : act_q);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (we_i) begin
      shd_d  = div_i;
      pend_d = 1'b1;
    end

    if (sync_hold) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (we_i || pend_q) begin
        act_d  = next_div;
        pend_d = 1'b0;
      end
    end else if (!running) begin
      cnt_d = '0;
      clk_d = 1'b0;
      // A write arriving now stays pending so the newest value wins next cycle.
      if (pend_q && !we_i) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      act_d  = next_div;
      pend_d = 1'b0;
      clk_d  = (next_div == '0) ? 1'b0 : ~clk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      act_q  <= DivW'(DivReset);
      shd_q  <= DivW'(DivReset);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/prescaler_bank.sv
// Bank of N_CH independent programmable clock prescalers sharing one config write port.
// Define PRESCALER_SYNC_EN to add the i_sync phase-alignment input.
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DIV_W     = DIV_W_DEF,
  parameter int unsigned DIV_RESET = DIV_RESET_DEF,
  parameter int unsigned CH_W      = ch_w(N_CH)
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef PRESCALER_SYNC_EN
  input  logic             i_sync,
`endif
  output logic [N_CH-1:0]  o_clk,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_pending
);

  logic cfg_valid;

  // Out-of-range channel indices are dropped here so no channel sees them.
  assign cfg_valid = cfg_we && (32'(cfg_ch) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_we;

    assign ch_we = cfg_valid && (32'(cfg_ch) == 32'(i));

    prescaler_channel #(
      .DivW     (DIV_W),
      .DivReset (DIV_RESET)
    ) u_ch (
      .clk_i     (sysclk),
      .rst_ni    (reset_n),
      .we_i      (ch_we),
      .div_i     (cfg_div),
`ifdef PRESCALER_SYNC_EN
      .sync_i    (i_sync),
`endif
      .clk_o     (o_clk[i]),
      .tick_o    (o_tick[i]),
      .pending_o (o_pending[i])
    );
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// Self-checking bench for prescaler_bank: table of divisor writes plus corner-case sequences.
module tb_prescaler_bank;

  localparam int unsigned NCh  = 4;
  localparam int unsigned DivW = 16;
  localparam int unsigned ChW  = 3;

  logic            sysclk  = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_we  = 1'b0;
  logic [ChW-1:0]  cfg_ch  = '0;
  logic [DivW-1:0] cfg_div = '0;
`ifdef PRESCALER_SYNC_EN
  logic            i_sync  = 1'b0;
`endif
  logic [NCh-1:0]  o_clk;
  logic [NCh-1:0]  o_tick;
  logic [NCh-1:0]  o_pending;

  prescaler_bank #(
    .N_CH      (NCh),
    .DIV_W     (DivW),
    .DIV_RESET (60),
    .CH_W      (ChW)
  ) dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef PRESCALER_SYNC_EN
    .i_sync    (i_sync),
`endif
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pending (o_pending)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ch;
    int div;
    bit sync;   // align to a tick of the channel before writing
    int off;    // cycles after that tick at which the write is driven
    int first;  // cycles from the write to the next tick
    bit pend;   // o_pending the cycle after the write
    int gap;    // tick spacing afterwards; 0 means the channel stops
  } vec_t;

  typedef struct {
    int ch;
    int first;
    bit pend;
    int gap;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts negedges until o_tick[ch]; k = -1 when the budget runs out.
  task automatic wait_tick(input int ch, input int budget, output int k);
    k = 0;
    forever begin
      @(negedge sysclk);
      k++;
      if (o_tick[ch]) return;
      if (k >= budget) begin
        k = -1;
        return;
      end
    end
  endtask

  // Channel 0 stays at the reset divisor while other channels are reprogrammed.
  bit mon_en  = 1'b0;
  int mon_gap = -1;
  always @(negedge sysclk) begin
    if (!mon_en) begin
      mon_gap = -1;
    end else begin
      if (mon_gap >= 0) mon_gap++;
      if (o_tick[0]) begin
        if (mon_gap >= 0) check("ch0_phase", mon_gap, 60);
        mon_gap = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   k;
    int   k2;
    bit   c1;
    exp_t e;
    if (v.sync) begin
      wait_tick(v.ch, 70000, k);
      check("sync_found", k > 0, 1);
      repeat (v.off) @(negedge sysclk);
    end
    cfg_we  = 1'b1;
    cfg_ch  = ChW'(v.ch);
    cfg_div = DivW'(v.div);
    sb_q.push_back('{v.ch, v.first, v.pend, v.gap});
    @(negedge sysclk);
    cfg_we = 1'b0;
    e = sb_q.pop_front();
    check("pend_after_write", o_pending[e.ch], e.pend);
    k = 1;
    if (!o_tick[e.ch]) begin
      wait_tick(e.ch, e.first + 10, k2);
      k = (k2 < 0) ? -1 : k2 + 1;
    end
    check("first_tick", k, e.first);
    check("pend_at_tick", o_pending[e.ch], 0);
    c1 = o_clk[e.ch];
    if (e.gap == 0) begin
      check("clk_stopped", c1, 0);
      wait_tick(e.ch, 130, k2);
      check("no_tick_stopped", k2, -1);
    end else begin
      wait_tick(e.ch, e.gap + 10, k2);
      check("tick_gap", k2, e.gap);
      check("clk_toggled", o_clk[e.ch], !c1);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int k;
    bit prev;
    vecs[0] = '{1, 5, 1, 20, 40, 1, 5};   // mid-period write, old half-period kept
    vecs[1] = '{3, 7, 1, 59, 1, 0, 7};    // write on the TC cycle bypasses shadow
    vecs[2] = '{1, 3, 1, 2, 3, 1, 3};
    vecs[3] = '{2, 0, 1, 10, 50, 1, 0};   // stop at next TC
    vecs[4] = '{2, 3, 0, 0, 5, 1, 3};     // restart a stopped channel
    vecs[5] = '{0, 1, 1, 0, 60, 1, 1};
    vecs[6] = '{3, 2, 1, 6, 1, 0, 2};

    repeat (3) @(negedge sysclk);
    check("rst_clk", o_clk, 0);
    check("rst_tick", o_tick, 0);
    check("rst_pending", o_pending, 0);
    reset_n = 1'b1;

    wait_tick(0, 80, k);
    check("default_first", k, 60);
    check("default_all_tick", o_tick, 4'hF);
    check("default_all_clk", o_clk, 4'hF);
    wait_tick(0, 80, k);
    check("default_gap", k, 60);
    check("default_clk_low", o_clk, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].ch == 0) mon_en = 1'b0;
      run_vec(vecs[i]);
    end

    // Divisor 1: tick held high, clock toggles every cycle.
    prev = o_clk[0];
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      check("d1_tick_high", o_tick[0], 1);
      check("d1_clk_toggle", o_clk[0], !prev);
      prev = o_clk[0];
    end

    // Out-of-range channel index must be ignored.
    cfg_we  = 1'b1;
    cfg_ch  = 3'd5;
    cfg_div = 16'd9;
    @(negedge sysclk);
    cfg_we = 1'b0;
    check("bad_ch_pending", o_pending, 0);
    wait_tick(1, 20, k);
    wait_tick(1, 20, k);
    check("bad_ch_ch1_gap", k, 3);
    wait_tick(3, 20, k);
    wait_tick(3, 20, k);
    check("bad_ch_ch3_gap", k, 2);

    // Reset mid-count with a write pending on ch1.
    wait_tick(1, 20, k);
    cfg_we  = 1'b1;
    cfg_ch  = 3'd1;
    cfg_div = 16'd9;
    @(negedge sysclk);
    cfg_we = 1'b0;
    check("rst_mid_pending_set", o_pending[1], 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_clk", o_clk, 0);
    check("rst_async_tick", o_tick, 0);
    check("rst_async_pending", o_pending, 0);
    @(negedge sysclk);
    reset_n = 1'b1;
    wait_tick(1, 80, k);
    check("rst_rel_first", k, 60);
    check("rst_rel_pending", o_pending, 0);
    wait_tick(1, 80, k);
    check("rst_rel_gap", k, 60);

`ifdef PRESCALER_SYNC_EN
    cfg_we  = 1'b1;
    cfg_ch  = 3'd0;
    cfg_div = 16'd4;
    @(negedge sysclk);
    cfg_ch = 3'd1;
    @(negedge sysclk);
    cfg_we = 1'b0;
    i_sync = 1'b1;
    @(negedge sysclk);
    i_sync = 1'b0;
    wait_tick(0, 20, k);
    check("sync_first_tick", k, 4);
    for (int i = 0; i < 12; i++) begin
      check("sync_clk_aligned", o_clk[1], o_clk[0]);
      check("sync_tick_aligned", o_tick[1], o_tick[0]);
      @(negedge sysclk);
    end
`endif

    run_vec('{3, 65535, 1, 59, 1, 0, 65535});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
